spike_synapse_decoder: RTL and testbench

//   Receiving end of the neuron spike interface: converts a 1-bit spike train

---
 rtl/spike_synapse_decoder.sv | 111 +++++++++++
 tb/tb_spike_synapse_decoder.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/spike_synapse_decoder.sv
// Spike-train receiver: rebuilds a leaky synaptic current from weighted spikes and
// measures the firing rate over a fixed window of enabled cycles.
module spike_synapse_decoder #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DECAY_SHIFT = 2,
  parameter int unsigned WINDOW      = 16,
  parameter int unsigned RATE_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              spike_in,
  input  logic [WIDTH-1:0]  weight,
  input  logic              inhibit,
  output logic [WIDTH-1:0]  current_out,
  output logic              sat_flag,
  output logic [RATE_W-1:0] rate_out,
  output logic              rate_valid
);

  localparam int unsigned WinW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int unsigned SumW = WIDTH + 2;
  localparam logic [WinW-1:0]        WinLast = WinW'(WINDOW - 1);
  localparam logic signed [SumW-1:0] CurMax  = {2'b00, {WIDTH{1'b1}}};

  logic [WIDTH-1:0]  cur_q, cur_d;
  logic              sat_q, sat_d;
  logic [RATE_W-1:0] rate_q, rate_d;
  logic              valid_q, valid_d;
  logic [WinW-1:0]   win_q, win_d;
  logic [RATE_W-1:0] spk_q, spk_d;

  logic [WIDTH-1:0]        shifted;
  logic [WIDTH-1:0]        leak;
  logic signed [SumW-1:0]  sum;
  logic [RATE_W-1:0]       spk_next;

  always_comb begin
    cur_d    = cur_q;
    sat_d    = 1'b0;
    rate_d   = rate_q;
    valid_d  = 1'b0;
    win_d    = win_q;
    spk_d    = spk_q;
    shifted  = cur_q >> DECAY_SHIFT;
    leak     = shifted;
    sum      = '0;
    spk_next = spk_q;

    // Small nonzero currents still leak by one so the current always reaches zero.
    if (shifted == '0 && cur_q != '0) begin
      leak = WIDTH'(1);
    end

    if (en) begin
      sum = $signed({2'b00, cur_q}) - $signed({2'b00, leak});
      if (spike_in) begin
        if (inhibit) sum = sum - $signed({2'b00, weight});
        else         sum = sum + $signed({2'b00, weight});
      end

      if (sum[SumW-1]) begin
        cur_d = '0;
      end else if (sum > CurMax) begin
        cur_d = '1;
        sat_d = 1'b1;
      end else begin
        cur_d = sum[WIDTH-1:0];
      end

      if (spike_in && spk_q != '1) begin
        spk_next = spk_q + RATE_W'(1);
      end

      // The closing cycle's spike is folded into the published count.
      if (win_q == WinLast) begin
        rate_d  = spk_next;
        valid_d = 1'b1;
        spk_d   = '0;
        win_d   = '0;
      end else begin
        spk_d = spk_next;
        win_d = win_q + WinW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_q   <= '0;
      sat_q   <= 1'b0;
      rate_q  <= '0;
      valid_q <= 1'b0;
      win_q   <= '0;
      spk_q   <= '0;
    end else begin
      cur_q   <= cur_d;
      sat_q   <= sat_d;
      rate_q  <= rate_d;
      valid_q <= valid_d;
      win_q   <= win_d;
      spk_q   <= spk_d;
    end
  end

  assign current_out = cur_q;
  assign sat_flag    = sat_q;
  assign rate_out    = rate_q;
  assign rate_valid  = valid_q;

endmodule

// File: tb/tb_spike_synapse_decoder.sv
// Bench for spike_synapse_decoder: directed scenarios plus random traffic against an
// integer reference model of the current and rate-window rules.
module tb_spike_synapse_decoder;

  localparam int WINDOW = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       spike_in = 1'b0;
  logic [7:0] weight = '0;
  logic       inhibit = 1'b0;
  logic [7:0] current_out;
  logic       sat_flag;
  logic [7:0] rate_out;
  logic       rate_valid;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_cur = 0, m_sat = 0, m_rate = 0, m_valid = 0, m_win = 0, m_spk = 0;

  spike_synapse_decoder #(
    .WIDTH      (8),
    .DECAY_SHIFT(2),
    .WINDOW     (WINDOW),
    .RATE_W     (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .spike_in   (spike_in),
    .weight     (weight),
    .inhibit    (inhibit),
    .current_out(current_out),
    .sat_flag   (sat_flag),
    .rate_out   (rate_out),
    .rate_valid (rate_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cur = 0; m_sat = 0; m_rate = 0; m_valid = 0; m_win = 0; m_spk = 0;
  endtask

  task automatic model_step(input bit e, input bit s, input int w, input bit i);
    int leak, v;
    m_sat   = 0;
    m_valid = 0;
    if (!e) return;
    leak = m_cur / 4;
    if (leak == 0 && m_cur > 0) leak = 1;
    v = m_cur - leak;
    if (s) v = i ? v - w : v + w;
    if (v > 255) begin
      v = 255;
      m_sat = 1;
    end
    if (v < 0) v = 0;
    m_cur = v;
    if (m_win == WINDOW - 1) begin
      m_rate  = (m_spk + s > 255) ? 255 : m_spk + s;
      m_valid = 1;
      m_spk   = 0;
      m_win   = 0;
    end else begin
      m_win = m_win + 1;
      m_spk = (m_spk + s > 255) ? 255 : m_spk + s;
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".cur"},   current_out, m_cur);
    check({tag, ".sat"},   sat_flag,    m_sat);
    check({tag, ".rate"},  rate_out,    m_rate);
    check({tag, ".valid"}, rate_valid,  m_valid);
  endtask

  // Called at a negedge: drive, let one posedge pass, compare at the next negedge.
  task automatic step(input string tag, input bit e, input bit s, input int w, input bit i);
    en = e; spike_in = s; weight = w[7:0]; inhibit = i;
    model_step(e, s, w, i);
    @(negedge clk);
    check_model(tag);
  endtask

  task automatic do_reset(input string tag);
    en = 1'(($urandom_range(0, 1)));
    spike_in = 1'(($urandom_range(0, 1)));
    weight = 8'($urandom);
    rst = 1'b1;
    model_reset();
    #1;
    check_model({tag, ".rst"});
    @(negedge clk);
    check_model({tag, ".rsthold"});
    rst = 1'b0;
  endtask

  initial begin
    int seq[16] = '{64, 48, 36, 27, 21, 16, 12, 9, 7, 6, 5, 4, 3, 2, 1, 0};

    // Reset state and idle running
    @(negedge clk);
    do_reset("t1");
    for (int k = 0; k < 20; k++) step("t1.idle", 1'b1, 1'b0, 0, 1'b0);
    check("t1.cur_zero", current_out, 0);

    // Single spike decay profile
    do_reset("t2");
    step("t2", 1'b1, 1'b1, 64, 1'b0);
    check("t2.seq0", current_out, seq[0]);
    for (int k = 1; k < 16; k++) begin
      step("t2", 1'b1, 1'b0, 64, 1'b0);
      check("t2.seq", current_out, seq[k]);
    end
    step("t2.hold", 1'b1, 1'b0, 64, 1'b0);
    check("t2.hold0", current_out, 0);

    // Upper saturation
    step("t3", 1'b1, 1'b1, 200, 1'b0);
    check("t3.first", current_out, 200);
    check("t3.nosat", sat_flag, 0);
    for (int k = 0; k < 3; k++) begin
      step("t3", 1'b1, 1'b1, 200, 1'b0);
      check("t3.clamp", current_out, 255);
      check("t3.satpulse", sat_flag, 1);
    end
    step("t3.decay", 1'b1, 1'b0, 200, 1'b0);
    check("t3.192", current_out, 192);
    check("t3.satclr", sat_flag, 0);

    // Inhibitory floor
    do_reset("t4");
    step("t4", 1'b1, 1'b1, 64, 1'b0);
    step("t4", 1'b1, 1'b0, 0, 1'b0);
    check("t4.48", current_out, 48);
    step("t4.inh", 1'b1, 1'b1, 100, 1'b1);
    check("t4.floor", current_out, 0);
    check("t4.floorsat", sat_flag, 0);
    step("t4.after", 1'b1, 1'b0, 100, 1'b1);
    check("t4.stay0", current_out, 0);

    // Rate window
    do_reset("t5");
    for (int k = 0; k < 16; k++) step("t5.alt", 1'b1, (k % 2) == 0, 0, 1'b0);
    check("t5.alt.valid", rate_valid, 1);
    check("t5.alt.rate", rate_out, 8);
    for (int k = 0; k < 16; k++) step("t5.all", 1'b1, 1'b1, 0, 1'b0);
    check("t5.all.rate", rate_out, 16);
    for (int k = 0; k < 16; k++) step("t5.last", 1'b1, k == 15, 0, 1'b0);
    check("t5.last.valid", rate_valid, 1);
    check("t5.last.rate", rate_out, 1);

    // Enable gating delays the pulse; reset discards partial window
    do_reset("t6");
    for (int k = 0; k < 5; k++) step("t6.pre", 1'b1, 1'b0, 0, 1'b0);
    for (int k = 0; k < 5; k++) step("t6.off", 1'b0, 1'b1, 255, 1'b0);
    for (int k = 0; k < 11; k++) step("t6.post", 1'b1, 1'b0, 0, 1'b0);
    check("t6.delayed", rate_valid, 1);
    for (int k = 0; k < 7; k++) step("t6.part", 1'b1, 1'b1, 10, 1'b0);
    do_reset("t6.mid");
    for (int k = 0; k < 16; k++) step("t6.fresh", 1'b1, 1'b1, 0, 1'b0);
    check("t6.fresh.valid", rate_valid, 1);
    check("t6.fresh.rate", rate_out, 16);

    // Random traffic
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset("rnd");
      end else begin
        step("rnd", $urandom_range(0, 7) != 0, $urandom_range(0, 2) == 0,
             int'($urandom_range(0, 255)), $urandom_range(0, 3) == 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
